shift_seq8: RTL and testbench
=============================

Name: shift_seq8

Overview:
- Multi-cycle shift sequencer built around a single-step 8-bit shifter stage. The stage shifts by 0..3 per cycle, like the existing 2-bit-shamt shifters.
- Accepts one shift request (op, data, 3-bit amount 0..7) with a start/busy/done handshake.
- Breaks the amount into steps of at most 3 and applies them over consecutive cycles.
- Sits between a control unit and the shifter datapath. It is the sequencer that lets a 2-bit shifter serve full 0..7 shifts.

Parameters:
- WIDTH, 8, data width in bits
- SHW, 3, request shift-amount width (amount range 0..2^SHW-1)
- STEP_MAX, 3, maximum shift applied per cycle (fixed by the 2-bit stage)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request strobe, sampled only in IDLE
- op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- d_in  input  WIDTH  operand, sampled with start
- shamt  input  SHW  total shift amount, sampled with start
- d_out  output  WIDTH  working/result register
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse, result valid
- remain  output  SHW  shift amount still outstanding (debug/observe)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, d_out=0, remain=0, busy=0, done=0; the latched op register also clears to 00. Takes effect immediately, including mid-operation; the in-flight request is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge k: latch op; d_out<=d_in; remain<=shamt. Next state is DONE if shamt==0, else SHIFT.
- SHIFT, each edge:
  - step = min(remain, STEP_MAX).
  - d_out <= step_unit(d_out, op, step); remain <= remain - step.
  - Go to DONE when remain - step == 0, else stay in SHIFT.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: n = ceil(shamt/3) SHIFT cycles. done is high in the cycle after edge k+n.
  - shamt=0 gives done in the cycle after edge k.
  - shamt=7 uses steps 3,3,1, so done follows edge k+3.
- busy is high in SHIFT and DONE. start while busy (including during DONE) is ignored with no side effects.
- d_out holds the result after DONE until the next accepted start.
- Shift semantics per step s:
  - LSL: zero fill from LSB.
  - LSR: zero fill from MSB.
  - ASR: replicate bit WIDTH-1 (sign) into the vacated MSBs.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- ASR by >= WIDTH-1 gives all-sign; with WIDTH=8 and SHW=3 the amount never exceeds 7, so there is no over-shift case.
- Inputs d_in, shamt and op may change freely while busy; only the latched copies are used.
- done and busy are registered or decoded from registered state only; no combinational path from start.

Decomposition:
- Shared include file holds:
  - op encodings (OP_LSL, OP_LSR, OP_ASR, OP_ROR)
  - FSM state encodings (ST_IDLE, ST_SHIFT, ST_DONE)
  - STEP_MAX
- One sub-module: shift_step8, combinational. Inputs d_in[WIDTH-1:0], op[1:0], step[1:0]; output d_out. It performs one 0..3 shift for all four ops. It is instantiated once; its output feeds the d_out register.
- The top level holds the FSM, remain counter and handshake.

Test Plan:
- ASR, d_in=8'h59, shamt=2, start one cycle -> one SHIFT cycle; d_out=8'h16 with done pulse; busy high 2 cycles; remain 2->0.
- ASR, d_in=8'hBB, shamt=7 -> remain 7,4,1,0 over three SHIFT cycles; final d_out=8'hFF; done exactly one cycle.
- LSL 8'hBB by 5 -> 8'h60 (steps 3,2). LSR 8'hBB by 6 -> 8'h02. ROR 8'h59 by 4 -> 8'h95.
- shamt=0, d_in=8'hBB -> done in the cycle after the start edge; d_out=8'hBB; no SHIFT state entered.
- start re-asserted with different d_in/shamt during SHIFT and during DONE -> ignored; the original result is produced; the next start after IDLE is accepted.
- reset_n pulled low mid-SHIFT of a 7-bit ASR -> d_out, remain, busy and done are 0 immediately. After release, a new request (LSR 8'h80 by 3 -> 8'h10) completes normally.

Source files
------------

// File: rtl/shift_seq8_pkg.sv
// Shared encodings and sizing for the shift_seq8 sequencer and its single-step stage.
package shift_seq8_pkg;

   localparam int WIDTH    = 8;
   localparam int SHW      = 3;
   localparam int STEP_MAX = 3;

   typedef enum logic [1:0] {
      OP_LSL = 2'b00,
      OP_LSR = 2'b01,
      OP_ASR = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_seq8_step.sv
// Single-step shifter: one 0..3 bit shift of an 8-bit word for all four shift ops.
module shift_step8
   import shift_seq8_pkg::*;
(
   input  logic [WIDTH-1:0] d_in,
   input  logic [1:0]       op,
   input  logic [1:0]       step,
   output logic [WIDTH-1:0] d_out
);

   localparam logic [3:0] W4 = 4'(WIDTH);

   always_comb begin
      d_out = d_in;
      case (op)
         OP_LSL:  d_out = d_in << step;
         OP_LSR:  d_out = d_in >> step;
         OP_ASR:  d_out = $signed(d_in) >>> step;
         // step==0 makes the left term shift by WIDTH, i.e. vanish.
         OP_ROR:  d_out = (d_in >> step) | (d_in << (W4 - {2'b00, step}));
         default: d_out = d_in;
      endcase
   end

endmodule

// File: rtl/shift_seq8.sv
// Shift sequencer: splits a 0..7 shift into steps of at most 3 applied on consecutive cycles.
module shift_seq8
   import shift_seq8_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] d_in,
   input  logic [SHW-1:0]   shamt,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done,
   output logic [SHW-1:0]   remain
);

   // Handshake: start is honoured only while busy is low; the request is
   // latched on that edge and done pulses for one cycle when d_out is final.
   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SHW-1:0]   remain_q, remain_d;
   logic [1:0]       step;
   logic [SHW-1:0]   remain_next;
   logic [WIDTH-1:0] step_out;

   always_comb begin
      step        = (remain_q > SHW'(STEP_MAX)) ? 2'(STEP_MAX) : remain_q[1:0];
      remain_next = remain_q - {{(SHW-2){1'b0}}, step};
   end

   shift_step8 u_step (
      .d_in  (data_q),
      .op    (op_q),
      .step  (step),
      .d_out (step_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_LSL;
         data_q   <= '0;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         remain_q <= remain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      remain_d = remain_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = op_e'(op);
               data_d   = d_in;
               remain_d = shamt;
               state_d  = (shamt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d   = step_out;
            remain_d = remain_next;
            if (remain_next == '0) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign d_out  = data_q;
   assign remain = remain_q;
   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq8.sv
// Directed bench for shift_seq8: vector table plus hand-written ignore/reset sequences.
module tb_shift_seq8;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [1:0] op;
   logic [7:0] d_in;
   logic [2:0] shamt;
   logic [7:0] d_out;
   logic       busy;
   logic       done;
   logic [2:0] remain;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [1:0] op;
      logic [7:0] d;
      logic [2:0] sh;
      logic [7:0] exp;
      int         cyc;
   } vec_t;

   vec_t vecs[12];

   shift_seq8 dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .d_in    (d_in),
      .shamt   (shamt),
      .d_out   (d_out),
      .busy    (busy),
      .done    (done),
      .remain  (remain)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it to completion; inputs get scrambled
   // after the accepting edge to show only the latched copy matters.
   task automatic run_req(input string name, input logic [1:0] o, input logic [7:0] d,
                          input logic [2:0] sh, input logic [7:0] exp, input int cyc);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; d_in = d; shamt = sh;
      tick();
      start = 1'b0;
      op    = 2'($urandom_range(0, 3));
      d_in  = 8'($urandom_range(0, 255));
      shamt = 3'($urandom_range(0, 7));
      chk({name, "_busy0"}, busy, 1'b1);
      n = 0;
      while (!done && n < 10) begin
         tick();
         n++;
      end
      chk({name, "_cyc"}, n, cyc);
      chk({name, "_dout"}, d_out, exp);
      chk({name, "_rem"}, remain, 3'd0);
      tick();
      chk({name, "_done_off"}, {busy, done}, 2'b00);
      chk({name, "_hold"}, d_out, exp);
   endtask

   initial begin
      vecs[0]  = '{2'b10, 8'h59, 3'd2, 8'h16, 1};
      vecs[1]  = '{2'b10, 8'hBB, 3'd7, 8'hFF, 3};
      vecs[2]  = '{2'b00, 8'hBB, 3'd5, 8'h60, 2};
      vecs[3]  = '{2'b01, 8'hBB, 3'd6, 8'h02, 2};
      vecs[4]  = '{2'b11, 8'h59, 3'd4, 8'h95, 2};
      vecs[5]  = '{2'b00, 8'hBB, 3'd0, 8'hBB, 0};
      vecs[6]  = '{2'b10, 8'h80, 3'd1, 8'hC0, 1};
      vecs[7]  = '{2'b11, 8'h01, 3'd7, 8'h02, 3};
      vecs[8]  = '{2'b00, 8'h01, 3'd7, 8'h80, 3};
      vecs[9]  = '{2'b10, 8'h7F, 3'd3, 8'h0F, 1};
      vecs[10] = '{2'b11, 8'hBB, 3'd3, 8'h77, 1};
      vecs[11] = '{2'b01, 8'hFF, 3'd4, 8'h0F, 2};

      reset_n = 1'b0; start = 1'b0; op = 2'b00; d_in = 8'h00; shamt = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", d_out, 8'h00);
      chk("rst_flags", {busy, done}, 2'b00);
      chk("rst_remain", remain, 3'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++)
         run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].sh, vecs[i].exp, vecs[i].cyc);

      // remain countdown for ASR 8'hBB by 7: 7,4,1,0
      @(negedge clk);
      start = 1'b1; op = 2'b10; d_in = 8'hBB; shamt = 3'd7;
      tick();
      start = 1'b0;
      chk("cnt_r7", remain, 3'd7);
      tick(); chk("cnt_r4", remain, 3'd4); chk("cnt_d4", done, 1'b0);
      tick(); chk("cnt_r1", remain, 3'd1); chk("cnt_d1", done, 1'b0);
      tick(); chk("cnt_r0", remain, 3'd0); chk("cnt_done", done, 1'b1);
      chk("cnt_dout", d_out, 8'hFF);
      tick(); chk("cnt_done_once", done, 1'b0);

      // start held high with other data through SHIFT and DONE is ignored
      @(negedge clk);
      start = 1'b1; op = 2'b10; d_in = 8'hBB; shamt = 3'd7;
      tick();
      op = 2'b00; d_in = 8'h01; shamt = 3'd1;
      tick(); chk("ign_s1", {busy, done}, 2'b10);
      tick(); chk("ign_s2", {busy, done}, 2'b10);
      tick(); chk("ign_done", {busy, done}, 2'b11);
      chk("ign_dout", d_out, 8'hFF);
      tick(); chk("ign_idle", {busy, done}, 2'b00);
      chk("ign_hold", d_out, 8'hFF);
      @(negedge clk);
      start = 1'b0;
      tick();
      run_req("after_ign", 2'b01, 8'hBB, 3'd6, 8'h02, 2);

      // async reset in the middle of a 7-bit ASR
      @(negedge clk);
      start = 1'b1; op = 2'b10; d_in = 8'hBB; shamt = 3'd7;
      tick();
      start = 1'b0;
      tick();
      chk("mid_busy", busy, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_dout", d_out, 8'h00);
      chk("mid_rst_rem", remain, 3'd0);
      chk("mid_rst_flags", {busy, done}, 2'b00);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("post_rst_idle", {busy, done}, 2'b00);
      run_req("post_rst", 2'b01, 8'h80, 3'd3, 8'h10, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout act=running exp=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
